uart_packet_rx: RTL and testbench
=================================

// Module: uart_packet_rx
// PURPOSE
//  Parametrised UART packet receiver: 8N1 serial deserialiser plus framing layer
//  checking STX header / ETX trailer over a fixed-length packet, with inter-byte
//  watchdog and error reporting. Sits between the board RXD pin and the AES/RAM
//  command path; delivers one whole packet per pkt_valid pulse.
// PARAMETERS
//  CLK_DIV      2500    clk cycles per bit (>=8); sample point = CLK_DIV/2
//  FRAME_BYTES  8       bytes per packet incl. STX and ETX (>=3)
//  STX          8'h02   required value of byte 0
//  ETX          8'h03   required value of byte FRAME_BYTES-1
//  TIMEOUT_CYC  500000  max idle clk cycles between bytes once packet started
// PORTS
//  clk          in   1              system clock
//  rst_n        in   1              async reset, active-low
//  rxd          in   1              serial input, idle high, asynchronous
//  pkt_data     out  8*FRAME_BYTES  byte k at [8k+7:8k], byte 0 = STX
//  pkt_valid    out  1              1-cycle pulse: pkt_data holds a good packet
//  busy         out  1              1 while packet in progress (byte0 accepted..end)
//  err_frame    out  1              1-cycle pulse: stop bit sampled 0
//  err_hdr      out  1              1-cycle pulse: byte 0 != STX
//  err_trl      out  1              1-cycle pulse: last byte != ETX
//  err_timeout  out  1              1-cycle pulse: watchdog expired
// BEHAVIOUR
//  - Reset (rst_n=0, async): all outputs 0, pkt_data=0, FSMs IDLE, counters 0.
//  - rxd passes a 2-FF synchroniser (reset value 1); all logic uses synced copy.
//  - Bit FSM: IDLE -> START on synced 1->0; START: at count CLK_DIV/2 rxd must be
//    0 else back to IDLE (glitch, no error); DATA: 8 samples every CLK_DIV cycles,
//    LSB first; STOP: sample one CLK_DIV later; 1 -> byte done, 0 -> err_frame.
//  - Byte done: byte index 0 compared with STX (mismatch -> err_hdr, drop, IDLE);
//    index FRAME_BYTES-1 compared with ETX (mismatch -> err_trl, drop).
//  - Any error: byte index -> 0, busy -> 0, pkt_data unchanged, one pulse only.
//  - Good packet: pkt_data updated and pkt_valid pulsed in the cycle after the
//    final stop-bit sample; pkt_data stable until the next good packet.
//  - Partial bytes go to a shadow buffer; pkt_data never shows a partial packet.
//  - Watchdog: counter cleared at every byte done; runs while busy and bit FSM in
//    IDLE; reaching TIMEOUT_CYC -> err_timeout, drop packet, index 0.
//  - Watchdog expiry same cycle as a start edge: timeout wins, edge is treated as
//    start of new byte 0. Stop-bit completion same cycle as expiry: completion wins.
//  - Back-to-back bytes (stop bit immediately followed by start) fully supported;
//    new start accepted from the cycle after the stop sample.
//  - Counters sized with $clog2; bit counter wraps at CLK_DIV-1, no overflow.
// CONFIGURATION
//  UART_PARITY_EN defined: frame is 8E1; PARITY state between DATA and STOP samples
//   even parity over 8 data bits; mismatch -> err_frame pulse, packet dropped.
//  Not defined: 8N1, no PARITY state, no parity logic synthesised.
// TESTING  (CLK_DIV=16, FRAME_BYTES=4, TIMEOUT_CYC=200 on bench)
//  1 send 02 AA 55 03 back-to-back -> one pkt_valid, pkt_data=32'h0355AA02, no err.
//  2 send 01 AA 55 03 -> err_hdr after byte 0, no pkt_valid; then 02 11 22 03 ->
//    pkt_valid, pkt_data=32'h03221102.
//  3 send 02 AA 55 04 -> err_trl pulse, pkt_data keeps previous value.
//  4 send 02 AA then idle 250 cycles -> err_timeout at 200 cycles after byte done,
//    busy falls; following full packet received correctly.
//  5 6-cycle low glitch on rxd -> no state change; byte with stop=0 -> err_frame.
//  6 assert rst_n low mid-byte 2 -> outputs 0 immediately; next packet good.
//    With UART_PARITY_EN: wrong parity on byte 1 -> err_frame, no pkt_valid.

Source files
------------

// File: rtl/uart_packet_rx.sv
// -----------------------------------------------------------------------------
// uart_packet_rx
//   UART packet receiver. An 8N1 serial deserialiser feeds a framing layer that
//   collects FRAME_BYTES bytes and checks the STX header and the ETX trailer.
//   An inter-byte watchdog drops a packet that stalls. A whole packet is
//   presented on pkt_data together with a one-cycle pkt_valid pulse.
//
//   Optional feature macro: UART_PARITY_EN
//     defined   -> 8E1 frames (even parity bit between data and stop bit);
//                  a parity mismatch reports err_frame and drops the packet.
//     undefined -> 8N1 frames, no parity logic.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous reset, active low
//   rxd          in   serial input (idle high, asynchronous to clk)
//   pkt_data     out  received packet, byte k at [8k+7:8k], byte 0 = STX
//   pkt_valid    out  1-cycle pulse, pkt_data holds a new good packet
//   busy         out  high from acceptance of byte 0 until the packet ends
//   err_frame    out  1-cycle pulse, stop bit (or parity) wrong
//   err_hdr      out  1-cycle pulse, byte 0 differs from STX
//   err_trl      out  1-cycle pulse, last byte differs from ETX
//   err_timeout  out  1-cycle pulse, inter-byte watchdog expired
// -----------------------------------------------------------------------------
module uart_packet_rx #(
    parameter int         CLK_DIV     = 2500,
    parameter int         FRAME_BYTES = 8,
    parameter logic [7:0] STX         = 8'h02,
    parameter logic [7:0] ETX         = 8'h03,
    parameter int         TIMEOUT_CYC = 500000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rxd,
    output logic [8*FRAME_BYTES-1:0] pkt_data,
    output logic                     pkt_valid,
    output logic                     busy,
    output logic                     err_frame,
    output logic                     err_hdr,
    output logic                     err_trl,
    output logic                     err_timeout
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(FRAME_BYTES);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BYTES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

`ifdef UART_PARITY_EN
    // Even parity: the transmitted parity bit equals the XOR of the data bits.
    function automatic logic even_parity(input logic [7:0] data);
        even_parity = ^data;
    endfunction
`endif

    logic                     rxd_meta_q;
    logic                     rxd_sync_q;
    logic                     rxd_prev_q;
    state_t                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [2:0]               bit_q;
    logic [7:0]               shift_q;
    logic [IDX_W-1:0]         idx_q;
    logic [WD_W-1:0]          wd_q;
    logic [8*FRAME_BYTES-1:0] shadow_q;
    logic [8*FRAME_BYTES-1:0] pkt_data_q;
    logic                     valid_q;
    logic                     busy_q;
    logic                     err_frame_q;
    logic                     err_hdr_q;
    logic                     err_trl_q;
    logic                     err_timeout_q;
    logic                     start_edge_s;
    logic                     par_bad_s;

`ifdef UART_PARITY_EN
    logic                     par_err_q;
    assign par_bad_s = par_err_q;
`else
    assign par_bad_s = 1'b0;
`endif

    // Falling edge of the synchronised line marks a candidate start bit.
    assign start_edge_s = rxd_prev_q & ~rxd_sync_q;

    // Two-flop synchroniser plus one history flop for edge detection; idle-high reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    // Bit-level receiver, framing layer and watchdog with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bit_q         <= 3'd0;
            shift_q       <= 8'h00;
            idx_q         <= '0;
            wd_q          <= '0;
            shadow_q      <= '0;
            pkt_data_q    <= '0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            err_frame_q   <= 1'b0;
            err_hdr_q     <= 1'b0;
            err_trl_q     <= 1'b0;
            err_timeout_q <= 1'b0;
`ifdef UART_PARITY_EN
            par_err_q     <= 1'b0;
`endif
        end else begin
            // Status outputs are single-cycle pulses unless set below.
            valid_q       <= 1'b0;
            err_frame_q   <= 1'b0;
            err_hdr_q     <= 1'b0;
            err_trl_q     <= 1'b0;
            err_timeout_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // Watchdog only runs between bytes of a started packet.
                    // Expiry is handled first; a simultaneous start edge still
                    // opens a new byte, which then counts as byte 0.
                    if (busy_q && (wd_q == WD_LAST)) begin
                        err_timeout_q <= 1'b1;
                        busy_q        <= 1'b0;
                        idx_q         <= '0;
                        wd_q          <= '0;
                    end else if (busy_q) begin
                        wd_q <= wd_q + WD_W'(1);
                    end else begin
                        wd_q <= '0;
                    end
                    if (start_edge_s) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                    end
                end

                ST_START: begin
                    // Re-check the line mid start bit; a high level is a glitch.
                    if (cnt_q == CNT_HALF) begin
                        cnt_q <= '0;
                        bit_q <= 3'd0;
                        if (!rxd_sync_q) begin
                            state_q <= ST_DATA;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rxd_sync_q, shift_q[7:1]};  // LSB arrives first
                        if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    // Remember a parity mismatch; it is reported at the stop bit.
                    if (cnt_q == CNT_LAST) begin
                        cnt_q     <= '0;
                        par_err_q <= (even_parity(shift_q) != rxd_sync_q);
                        state_q   <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`endif

                ST_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                        wd_q    <= '0;
                        if (!rxd_sync_q || par_bad_s) begin
                            err_frame_q <= 1'b1;
                            idx_q       <= '0;
                            busy_q      <= 1'b0;
                        end else if (idx_q == '0) begin
                            if (shift_q != STX) begin
                                err_hdr_q <= 1'b1;
                            end else begin
                                shadow_q[7:0] <= shift_q;
                                idx_q         <= IDX_W'(1);
                                busy_q        <= 1'b1;
                            end
                        end else if (idx_q == IDX_LAST) begin
                            idx_q  <= '0;
                            busy_q <= 1'b0;
                            if (shift_q != ETX) begin
                                err_trl_q <= 1'b1;
                            end else begin
                                // Whole packet moves out at once; pkt_data never
                                // shows a partially received packet.
                                pkt_data_q <= {shift_q, shadow_q[8*(FRAME_BYTES-1)-1:0]};
                                valid_q    <= 1'b1;
                            end
                        end else begin
                            shadow_q[{idx_q, 3'b000} +: 8] <= shift_q;
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign pkt_data    = pkt_data_q;
    assign pkt_valid   = valid_q;
    assign busy        = busy_q;
    assign err_frame   = err_frame_q;
    assign err_hdr     = err_hdr_q;
    assign err_trl     = err_trl_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_packet_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_packet_rx
//   Directed bench for uart_packet_rx (CLK_DIV=16, FRAME_BYTES=4, TIMEOUT=200).
//   A packet-level model predicts the sequence of status pulses and the packet
//   contents from the bytes sent; a compare process matches every DUT pulse
//   and the pkt_data value against that model on each clock.
// -----------------------------------------------------------------------------
module tb_uart_packet_rx;

    localparam int CLK_DIV = 16;
    localparam int FB      = 4;
    localparam int TO      = 200;

    localparam int K_VALID = 0;
    localparam int K_FRAME = 1;
    localparam int K_HDR   = 2;
    localparam int K_TRL   = 3;
    localparam int K_TMO   = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        rxd   = 1'b1;
    logic [31:0] pkt_data;
    logic        pkt_valid, busy, err_frame, err_hdr, err_trl, err_timeout;

    uart_packet_rx #(
        .CLK_DIV    (CLK_DIV),
        .FRAME_BYTES(FB),
        .STX        (8'h02),
        .ETX        (8'h03),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .pkt_data   (pkt_data),
        .pkt_valid  (pkt_valid),
        .busy       (busy),
        .err_frame  (err_frame),
        .err_hdr    (err_hdr),
        .err_trl    (err_trl),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          idle_start = 0;
    int          n_ev[5] = '{default: 0};
    int          model_idx = 0;
    logic [31:0] model_shadow = 32'h0;
    logic [31:0] model_pkt = 32'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Packet-level rules: what one received byte does to the packet in progress.
    task automatic model_byte(input logic [7:0] b, input logic stop_ok, input logic par_ok);
        if (!stop_ok || !par_ok) begin
            push_ev(K_FRAME, 32'h0);
            model_idx = 0;
        end else if (model_idx == 0) begin
            if (b != 8'h02) begin
                push_ev(K_HDR, 32'h0);
            end else begin
                model_shadow[7:0] = b;
                model_idx = 1;
            end
        end else if (model_idx == FB - 1) begin
            if (b != 8'h03) begin
                push_ev(K_TRL, 32'h0);
            end else begin
                model_shadow[31:24] = b;
                push_ev(K_VALID, model_shadow);
            end
            model_idx = 0;
        end else begin
            model_shadow[model_idx*8 +: 8] = b;
            model_idx++;
        end
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input logic par_ok);
        model_byte(b, stop, par_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_PARITY_EN
        drive_bit((^b) ^ ~par_ok);
`endif
        drive_bit(stop);
        rxd = 1'b1;
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0, 1'b1, 1'b1);
        send_byte(b1, 1'b1, 1'b1);
        send_byte(b2, 1'b1, 1'b1);
        send_byte(b3, 1'b1, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) until every predicted pulse has been observed.
    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    logic [4:0] pulses;
    int         kind;
    ev_t        e_obs;

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            check("outputs_in_reset",
                  {pkt_data, busy, pkt_valid, err_frame, err_hdr, err_trl, err_timeout},
                  64'h0);
        end else begin
            pulses = {err_timeout, err_trl, err_hdr, err_frame, pkt_valid};
            if (pulses != 5'b00000) begin
                kind = 0;
                for (int i = 4; i >= 0; i--) if (pulses[i]) kind = i;
                n_ev[kind]++;
                check("single_pulse", $countones(pulses), 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got kind %0d expected none", kind);
                end else begin
                    e_obs = exp_q.pop_front();
                    check("event_kind", kind, e_obs.kind);
                    if (e_obs.kind == K_VALID) begin
                        check("pkt_data_on_valid", pkt_data, e_obs.data);
                        model_pkt = e_obs.data;
                    end
                    if (kind == K_TMO) begin
                        checks++;
                        if ((cyc - idle_start) < 190 || (cyc - idle_start) > 205) begin
                            errors++;
                            $display("FAIL timeout_latency: got %0d cycles expected 190..205",
                                     cyc - idle_start);
                        end
                    end
                end
            end
            check("pkt_data_stable", pkt_data, model_pkt);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        #2 rst_n = 1'b0;
        idle(3);
        check("reset_pkt_data", pkt_data, 32'h0);
        check("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        idle(5);

        // 1: good packet, back to back
        send_byte(8'h02, 1'b1, 1'b1);
        check("busy_after_stx", busy, 1'b1);
        send_byte(8'hAA, 1'b1, 1'b1);
        send_byte(8'h55, 1'b1, 1'b1);
        send_byte(8'h03, 1'b1, 1'b1);
        drain("t1_drain");
        check("t1_pkt_data", pkt_data, 32'h0355AA02);
        check("t1_valid_count", n_ev[K_VALID], 1);
        check("t1_no_errors", n_ev[K_FRAME] + n_ev[K_HDR] + n_ev[K_TRL] + n_ev[K_TMO], 0);
        check("t1_busy_end", busy, 1'b0);

        // 2: bad header, every byte rejected as a header; then a good packet
        send_pkt(8'h01, 8'hAA, 8'h55, 8'h03);
        drain("t2a_drain");
        check("t2_hdr_count", n_ev[K_HDR], 4);
        check("t2_no_valid", n_ev[K_VALID], 1);
        send_pkt(8'h02, 8'h11, 8'h22, 8'h03);
        drain("t2b_drain");
        check("t2_pkt_data", pkt_data, 32'h03221102);

        // 3: bad trailer keeps previous packet
        send_pkt(8'h02, 8'hAA, 8'h55, 8'h04);
        drain("t3_drain");
        check("t3_trl_count", n_ev[K_TRL], 1);
        check("t3_pkt_kept", pkt_data, 32'h03221102);

        // 4: watchdog expiry, then a good packet
        send_byte(8'h02, 1'b1, 1'b1);
        send_byte(8'hAA, 1'b1, 1'b1);
        idle_start = cyc;
        push_ev(K_TMO, 32'h0);
        model_idx = 0;
        idle(100);
        check("t4_busy_waiting", busy, 1'b1);
        idle(150);
        check("t4_busy_after_tmo", busy, 1'b0);
        drain("t4a_drain");
        check("t4_tmo_count", n_ev[K_TMO], 1);
        send_pkt(8'h02, 8'hC3, 8'h3C, 8'h03);
        drain("t4b_drain");
        check("t4_pkt_data", pkt_data, 32'h033CC302);

        // 5: short glitch ignored; stop bit low reports a framing error
        rxd = 1'b0;
        idle(6);
        rxd = 1'b1;
        idle(40);
        check("t5_glitch_busy", busy, 1'b0);
        check("t5_glitch_events", n_ev[K_FRAME] + n_ev[K_HDR], 4);
        send_byte(8'h5A, 1'b0, 1'b1);
        idle(20);
        drain("t5_drain");
        check("t5_frame_count", n_ev[K_FRAME], 1);

        // 6: reset in the middle of byte 2
        send_byte(8'h02, 1'b1, 1'b1);
        send_byte(8'hAA, 1'b1, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        #2;
        rst_n     = 1'b0;
        model_pkt = 32'h0;
        model_idx = 0;
        exp_q.delete();
        #1;
        check("t6_async_pkt_data", pkt_data, 32'h0);
        check("t6_async_busy", busy, 1'b0);
        rxd = 1'b1;
        @(negedge clk);
        idle(3);
        rst_n = 1'b1;
        idle(5);
        send_pkt(8'h02, 8'hAA, 8'h55, 8'h03);
        drain("t6_drain");
        check("t6_pkt_data", pkt_data, 32'h0355AA02);

`ifdef UART_PARITY_EN
        // 7: wrong parity on byte 1 drops the packet
        send_byte(8'h02, 1'b1, 1'b1);
        send_byte(8'hAA, 1'b1, 1'b0);
        send_byte(8'h55, 1'b1, 1'b1);
        send_byte(8'h03, 1'b1, 1'b1);
        drain("t7_drain");
        check("t7_frame_count", n_ev[K_FRAME], 2);
        check("t7_pkt_kept", pkt_data, 32'h0355AA02);
`endif

        idle(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
